// File: rtl/nfc_frame_scheduler.sv
// Frame scheduler between the hex-line parser and the NFC transmitter: buffers one
// frame, replays it under valid/ready, then waits for a response or a timeout.
module nfc_frame_scheduler #(
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 1000000
) (
    input  logic       rstn,
    input  logic       clk,
    input  logic       i_tvalid,
    input  logic [7:0] i_tdata,
    input  logic [3:0] i_tdatab,
    input  logic       i_tlast,
    output logic       o_tvalid,
    input  logic       o_tready,
    output logic [7:0] o_tdata,
    output logic [3:0] o_tdatab,
    output logic       o_tlast,
    input  logic       rx_done,
    output logic       timeout,
    output logic       busy,
    output logic [7:0] drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_MAX    = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
    localparam logic [AW:0]   LEN_ONE    = (AW + 1)'(1'b1);
    localparam logic [31:0]   TIMER_INIT = 32'(TIMEOUT);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DROP    = 2'd1,
        SEND    = 2'd2,
        WAIT    = 2'd3
    } state_t;

    state_t        state_r;
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   len_r;
    logic [3:0]    lastb_r;
    logic [31:0]   timer_r;
    logic          in_frame_r;
    logic          discard_r;

    logic          foreign_s;
    logic          drop_inc_s;
    logic          discard_s;
    logic [7:0]    drop_nx_s;
    logic [AW-1:0] rptr_nx_s;
    logic          last_nx_s;
    logic          hs_s;

    assign busy = (state_r != COLLECT);

    // Next-value helpers: foreign-frame detection, discard tracking, drop counting
    always_comb begin
        foreign_s  = 1'b0;
        drop_inc_s = 1'b0;
        discard_s  = discard_r;
        if ((state_r == SEND) || (state_r == WAIT)) begin
            foreign_s = i_tvalid && !in_frame_r;
        end else begin
            foreign_s = 1'b0;
        end
        if ((state_r == COLLECT) && i_tvalid && !i_tlast && (wptr_r == PTR_MAX)) begin
            drop_inc_s = 1'b1;
        end else begin
            drop_inc_s = foreign_s;
        end
        // Leaving WAIT must see a discard raised by a foreign byte in that same cycle
        if (foreign_s) begin
            discard_s = !i_tlast;
        end else if ((state_r != COLLECT) && i_tvalid && i_tlast) begin
            discard_s = 1'b0;
        end else begin
            discard_s = discard_r;
        end
        if (drop_inc_s && (drop_cnt != 8'hFF)) begin
            drop_nx_s = drop_cnt + 8'd1;
        end else begin
            drop_nx_s = drop_cnt;
        end
        hs_s      = o_tvalid && o_tready;
        rptr_nx_s = rptr_r + PTR_ONE;
        last_nx_s = ({1'b0, rptr_nx_s} == (len_r - LEN_ONE));
    end

    // Frame buffer write port (contents are don't-care after reset)
    always_ff @(posedge clk) begin
        if ((state_r == COLLECT) && i_tvalid) begin
            mem_r[wptr_r] <= i_tdata;
        end
    end

    // Main FSM with registered transmitter-side outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= COLLECT;
            wptr_r     <= '0;
            rptr_r     <= '0;
            len_r      <= '0;
            lastb_r    <= 4'd8;
            timer_r    <= 32'd0;
            in_frame_r <= 1'b0;
            discard_r  <= 1'b0;
            o_tvalid   <= 1'b0;
            o_tdata    <= 8'd0;
            o_tdatab   <= 4'd8;
            o_tlast    <= 1'b0;
            timeout    <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            if (i_tvalid) begin
                in_frame_r <= !i_tlast;
            end
            discard_r <= discard_s;
            drop_cnt  <= drop_nx_s;
            timeout   <= 1'b0;
            case (state_r)
                COLLECT: begin
                    if (i_tvalid) begin
                        if (i_tlast) begin
                            len_r    <= {1'b0, wptr_r} + LEN_ONE;
                            lastb_r  <= i_tdatab;
                            wptr_r   <= '0;
                            state_r  <= SEND;
                            o_tvalid <= 1'b1;
                            // Slot 0 is being written this cycle for a single-byte frame
                            o_tdata  <= (wptr_r == '0) ? i_tdata : mem_r[0];
                            o_tlast  <= (wptr_r == '0);
                            o_tdatab <= (wptr_r == '0) ? i_tdatab : 4'd8;
                        end else if (wptr_r == PTR_MAX) begin
                            wptr_r  <= '0;
                            state_r <= DROP;
                        end else begin
                            wptr_r <= wptr_r + PTR_ONE;
                        end
                    end
                end
                DROP: begin
                    if (i_tvalid && i_tlast) begin
                        state_r <= COLLECT;
                    end
                end
                SEND: begin
                    if (hs_s) begin
                        if (o_tlast) begin
                            rptr_r   <= '0;
                            timer_r  <= TIMER_INIT;
                            state_r  <= WAIT;
                            o_tvalid <= 1'b0;
                            o_tdata  <= 8'd0;
                            o_tdatab <= 4'd8;
                            o_tlast  <= 1'b0;
                        end else begin
                            rptr_r   <= rptr_nx_s;
                            o_tdata  <= mem_r[rptr_nx_s];
                            o_tlast  <= last_nx_s;
                            o_tdatab <= last_nx_s ? lastb_r : 4'd8;
                        end
                    end
                end
                WAIT: begin
                    timer_r <= timer_r - 32'd1;
                    if (rx_done) begin
                        state_r <= discard_s ? DROP : COLLECT;
                    end else if (timer_r == 32'd1) begin
                        timeout <= 1'b1;
                        state_r <= discard_s ? DROP : COLLECT;
                    end
                end
                default: begin
                    state_r <= COLLECT;
                end
            endcase
        end
    end
endmodule

// File: doc/nfc_frame_scheduler.md
# nfc_frame_scheduler

Frame-level scheduler between the UART hex-line parser and the NFC transmitter. It captures one parsed frame (bytes plus final-byte bit count) into a local flop buffer, then replays it to the transmitter under a valid/ready handshake. It then holds off the next frame until the receiver reports a response or a response timeout expires. Frames that arrive while a frame is in flight, or that exceed the buffer, are discarded whole and counted.

## Interface
- DEPTH, 64: buffer capacity in bytes. Power of two, ≥2.
- TIMEOUT, 1000000: response wait in clk cycles, ≥1.

- rstn  in  1  asynchronous active-low reset
- clk  in  1  single clock for all logic
- i_tvalid  in  1  parser byte strobe (no backpressure)
- i_tdata  in  8  parser byte
- i_tdatab  in  4  valid bit count of the byte (8 = full byte; 1..7 only on the last byte)
- i_tlast  in  1  last byte of frame
- o_tvalid  out  1  byte to transmitter valid
- o_tready  in  1  transmitter accepts byte
- o_tdata  out  8  byte to transmitter
- o_tdatab  out  4  bit count: stored i_tdatab of the last byte when o_tlast, else 8
- o_tlast  out  1  last byte of frame
- rx_done  in  1  single-cycle pulse: NFC response received
- timeout  out  1  single-cycle pulse: response wait expired
- busy  out  1  state ≠ COLLECT
- drop_cnt  out  8  dropped-frame count, saturates at 255

## Operation
- Registers:
  - mem[DEPTH]×8: flop array.
  - wptr, rptr: clog2(DEPTH) bits.
  - len: clog2(DEPTH)+1 bits.
  - lastb: 4 bits.
  - timer: 32 bits.
  - in_frame, discard: 1 bit each.
  - state.
- in_frame tracks the parser stream in every state: set on i_tvalid&~i_tlast, cleared on i_tvalid&i_tlast.
- COLLECT, on i_tvalid:
  - Write mem[wptr].
  - If i_tlast: len←wptr+1, lastb←i_tdatab, wptr←0, go SEND.
  - Else if wptr==DEPTH-1: overflow. drop_cnt+1, wptr←0, go DROP.
  - Else wptr+1.
- DROP:
  - Ignore bytes.
  - On i_tvalid&i_tlast: discard←0, go COLLECT.
- SEND:
  - o_tvalid=1, o_tdata=mem[rptr], o_tlast=(rptr==len-1).
  - On o_tvalid&o_tready: rptr+1.
  - On the last beat: rptr←0, timer←TIMEOUT, go WAIT.
  - o_tvalid never drops until the handshake completes. o_tdata/o_tlast/o_tdatab are stable while stalled.
- WAIT:
  - timer decrements each cycle.
  - rx_done → leave.
  - Else timer==1 → timeout pulse (registered, asserted the cycle after), leave.
  - Leave = go DROP if discard, else COLLECT.
- Foreign bytes in SEND/WAIT:
  - An i_tvalid with in_frame==0 starts a new frame and is dropped: drop_cnt+1.
  - If that byte is not last, discard←1.
  - Further bytes are ignored; a tlast seen while discard=1 in SEND/WAIT clears discard.
- rx_done outside WAIT is ignored.
- drop_cnt saturates: 255+1=255.

## Timing
- Reset values:
  - Outputs: o_tvalid, o_tlast, timeout, busy, drop_cnt = 0; o_tdata = 0; o_tdatab = 8.
  - State/registers: state=COLLECT; wptr, rptr, len, timer, in_frame, discard = 0; lastb=8.
  - mem is not reset.
- Reset mid-frame (any state) abandons the frame, with no counting and no output beat.
- Latency: i_tlast accepted in cycle N → o_tvalid=1 in N+1. Max throughput is 1 byte/cycle with o_tready held high.
- Handshake on the final beat in cycle M → state WAIT from M+1, busy stays 1.
- rx_done sampled in cycle K → COLLECT at K+1. Bytes with i_tvalid in cycle K are still treated as foreign.
- rx_done coincident with timer==1 → rx_done wins, no timeout pulse.
- Without rx_done, timeout pulses exactly TIMEOUT+1 cycles after the final handshake cycle, and COLLECT is re-entered the same cycle the pulse is high.
- Frame of exactly DEPTH bytes is accepted. A non-last DEPTH-th byte is an overflow.
- Single-byte frame: len=1; o_tlast=1 on the first beat.
- busy is combinational from state.

## Test plan
- Basic frame: bytes 0x26, 0x01 (tdatab 7, last); o_tready=1; rx_done 5 cycles after the last beat.
  - Expect beats 0x26/8/0, then 0x01/7/1.
  - Expect busy 1→0 one cycle after rx_done; drop_cnt=0.
- Backpressure: 4-byte frame, o_tready toggled 1-0-0-1 repeatedly.
  - Expect 4 beats in order; outputs held stable during stalls.
- Timeout: TIMEOUT=20, 1-byte frame, no rx_done.
  - Expect timeout high for one cycle 21 cycles after the handshake, then busy=0.
  - Repeat with rx_done on the timer==1 cycle: expect no pulse.
- Overflow: DEPTH=8; a 9-byte frame, then a 3-byte frame.
  - Expect the first dropped (drop_cnt=1, no output), the second sent intact.
  - An 8-byte frame is sent intact.
- Foreign frame: a 3-byte frame arrives during WAIT, its tlast after rx_done.
  - Expect drop_cnt+1, DROP until that tlast, and no fragment output.
  - The next frame is sent normally.
- Reset mid-SEND: assert rstn low after beat 2 of 5.
  - Expect all outputs at reset values asynchronously.
  - Expect a clean next frame.
